// File: rtl/inst_encoder_pkg.sv
// Shared types and helpers for the RISC-V instruction encoder.
package riscv_enc_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {FMT_I, FMT_S, FMT_B, FMT_BAD} fmt_e;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   // Map an opcode onto the encoding format it needs.
   function automatic fmt_e fmtOf(input logic [6:0] opc);
      fmt_e f;
      case (opc)
         OPC_OP_IMM: f = FMT_I;
         OPC_STORE:  f = FMT_S;
         OPC_BRANCH: f = FMT_B;
         default:    f = FMT_BAD;
      endcase
      return f;
   endfunction

   // True when imm is representable as a 12-bit signed value.
   function automatic logic fitsImm12(input logic [31:0] imm);
      return (&imm[31:11]) || (~|imm[31:11]);
   endfunction

   // True when imm is an even 13-bit signed byte offset.
   function automatic logic fitsImmB(input logic [31:0] imm);
      return ((&imm[31:12]) || (~|imm[31:12])) && !imm[0];
   endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of the encoder.
interface inst_encoder_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic              in_ready;
   logic [6:0]        in_opcode;
   logic [2:0]        in_funct3;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [31:0]       in_imm;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_inst;
   logic [ADDR_W-1:0] out_addr;

   // Encoder side: consumes bundles, produces words.
   modport slave (
      input  in_valid, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm, in_last,
      output in_ready,
      output out_valid, out_inst, out_addr,
      input  out_ready
   );

   // Environment side: produces bundles, consumes words.
   modport master (
      output in_valid, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm, in_last,
      input  in_ready,
      input  out_valid, out_inst, out_addr,
      output out_ready
   );
endinterface

// File: rtl/inst_encoder_pack.sv
// Combinational packer: turns one field bundle into an instruction word
// and reports whether the opcode and immediate can be encoded.
module inst_pack
   import riscv_enc_pkg::*;
(
   input  logic [6:0]  i_opcode,
   input  logic [2:0]  i_funct3,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [31:0] i_imm,
   output logic [31:0] o_inst,
   output logic        o_legal
);

   fmt_e w_fmt;

   // Select the bit layout by format and check the immediate range.
   always_comb begin
      w_fmt   = fmtOf(i_opcode);
      o_inst  = '0;
      o_legal = 1'b0;
      case (w_fmt)
         FMT_I: begin
            o_inst  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            o_legal = fitsImm12(i_imm);
         end
         FMT_S: begin
            o_inst  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            o_legal = fitsImm12(i_imm);
         end
         FMT_B: begin
            o_inst  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                       i_imm[4:1], i_imm[11], i_opcode};
            o_legal = fitsImmB(i_imm);
         end
         default: begin
            o_inst  = '0;
            o_legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// Streaming instruction encoder: run control, one-deep output register,
// write-address counter and saturating rejected-bundle counter.
module inst_encoder
   import riscv_enc_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   inst_encoder_if.slave     bus,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ERR_W-1:0]  err_cnt
);

   state_e            r_state;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [ERR_W-1:0]  r_errCnt;
   logic              r_outValid;
   logic [31:0]       r_outInst;
   logic [ADDR_W-1:0] r_addr;

   logic [31:0]       w_inst;
   logic              w_legal;
   logic              w_inFire;
   logic              w_outFire;
   logic              w_inReady;

   inst_pack u_pack (
      .i_opcode (bus.in_opcode),
      .i_funct3 (bus.in_funct3),
      .i_rd     (bus.in_rd),
      .i_rs1    (bus.in_rs1),
      .i_rs2    (bus.in_rs2),
      .i_imm    (bus.in_imm),
      .o_inst   (w_inst),
      .o_legal  (w_legal)
   );

   // A bundle can enter whenever the output register is empty or being emptied this cycle.
   assign w_inReady = (r_state == RUN) && (!r_outValid || bus.out_ready);
   assign w_inFire  = bus.in_valid && w_inReady;
   assign w_outFire = r_outValid && bus.out_ready;

   assign bus.in_ready  = w_inReady;
   assign bus.out_valid = r_outValid;
   assign bus.out_inst  = r_outInst;
   assign bus.out_addr  = r_addr;
   assign busy          = r_busy;
   assign done          = r_done;
   assign err           = r_err;
   assign err_cnt       = r_errCnt;

   // Run FSM together with the output word, address and error bookkeeping.
   // An illegal last bundle can only be accepted when the output register ends
   // up empty, so it goes straight to DONE; a legal last drains its word first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_errCnt   <= '0;
         r_outValid <= 1'b0;
         r_outInst  <= '0;
         r_addr     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state  <= RUN;
                  r_busy   <= 1'b1;
                  r_addr   <= base_addr;
                  r_err    <= 1'b0;
                  r_errCnt <= '0;
               end
            end
            RUN: begin
               if (w_outFire) begin
                  r_outValid <= 1'b0;
                  r_addr     <= r_addr + ADDR_W'(4);
               end
               if (w_inFire) begin
                  if (w_legal) begin
                     r_outValid <= 1'b1;
                     r_outInst  <= w_inst;
                  end else begin
                     r_err <= 1'b1;
                     if (r_errCnt != '1) begin
                        r_errCnt <= r_errCnt + ERR_W'(1);
                     end
                  end
                  if (bus.in_last) begin
                     if (!w_legal) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= DRAIN;
                     end
                  end
               end
            end
            DRAIN: begin
               if (w_outFire) begin
                  r_outValid <= 1'b0;
                  r_addr     <= r_addr + ADDR_W'(4);
               end
               if (!r_outValid || w_outFire) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
